// File: rtl/daric_pkg.sv
// Shared definitions for the operand datapath blocks: default operand width,
// the operand type and the pointer-width helper.
package daric_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] data_t;

    // A two-entry buffer still needs a one-bit pointer, so clamp the width at 1
    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/operand_fifo_if.sv
// Valid/ready handshake bundle between producer, operand_fifo and consumer.
// The slave modport is the FIFO's view; master is the producer/consumer side.
interface operand_fifo_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fifo_ptr_ctr.sv
// AW-bit wrapping pointer with increment enable; synchronous clear wins over
// increment.
module fifo_ptr_ctr #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/operand_fifo.sv
// Elastic register-based operand buffer behind the PE output stage.
// Define OPERAND_FIFO_BYPASS_EN for a same-cycle path when the buffer is empty.
module operand_fifo
    import daric_pkg::*;
#(
    parameter int DATA_W   = daric_pkg::DATA_W,
    parameter int DEPTH    = 4,
    parameter int AFULL_TH = 3,
    localparam int AW      = ptr_w(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    operand_fifo_if.slave       bus,
    output logic [AW:0]         count,
    output logic                almost_full
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       count_q;
    logic [AW:0]       count_d;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              not_empty;
    logic              push;
    logic              pop;

    assign not_empty   = (count_q != '0);
    assign bus.in_ready = (count_q != (AW + 1)'(DEPTH));

`ifdef OPERAND_FIFO_BYPASS_EN
    logic byp;

    // An empty buffer hands the incoming word straight through; it is only
    // stored when the consumer cannot take it this cycle.
    assign byp          = !not_empty && bus.in_valid;
    assign bus.out_valid = not_empty || byp;
    assign bus.out_data  = not_empty ? mem_q[rd_ptr] :
                           (byp ? bus.in_data : '0);
    assign push = bus.in_valid && bus.in_ready && !(byp && bus.out_ready);
    assign pop  = not_empty && bus.out_ready;
`else
    assign bus.out_valid = not_empty;
    assign bus.out_data  = not_empty ? mem_q[rd_ptr] : '0;
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;
`endif

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flush discards the word offered in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !flush) begin
            mem_q[wr_ptr] <= bus.in_data;
        end
    end

    fifo_ptr_ctr #(.AW(AW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flush),
        .inc_i (push),
        .ptr_o (wr_ptr)
    );

    fifo_ptr_ctr #(.AW(AW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flush),
        .inc_i (pop),
        .ptr_o (rd_ptr)
    );

    assign count       = count_q;
    assign almost_full = (count_q >= (AW + 1)'(AFULL_TH));

endmodule

// File: tb/tb_operand_fifo.sv
// Directed self-checking bench for operand_fifo (DEPTH=4, AFULL_TH=3),
// covering both builds of OPERAND_FIFO_BYPASS_EN.
module tb_operand_fifo;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [2:0] count;
    logic       almost_full;
    int         checks;
    int         errors;

    operand_fifo_if #(.DATA_W(32)) bus ();

    operand_fifo #(
        .DATA_W   (32),
        .DEPTH    (4),
        .AFULL_TH (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .bus         (bus),
        .count       (count),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] fill [4];
    logic [31:0] q [$];
    logic [31:0] head;

    initial begin
        checks = 0;
        errors = 0;
        fill[0] = 32'h11; fill[1] = 32'h22; fill[2] = 32'h33; fill[3] = 32'h44;

        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  bus.out_data, 32'd0);
        chk("rst_count",     32'(count), 32'd0);
        chk("rst_afull",     32'(almost_full), 32'd0);
        rst_n = 1'b1;

        // Fill with consumer stalled
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = fill[i];
            step();
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_afull", 32'(almost_full), (i + 1 >= 3) ? 32'd1 : 32'd0);
        end
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_head",     bus.out_data, 32'h11);
        bus.in_data = 32'h55;
        step();
        chk("full_reject_count", 32'(count), 32'd4);
        chk("full_reject_head",  bus.out_data, 32'h11);
        bus.in_valid = 1'b0;

        // Drain in order
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(bus.out_valid), 32'd1);
            chk("drain_data",  bus.out_data, fill[i]);
            step();
        end
        chk("drained_valid", 32'(bus.out_valid), 32'd0);
        chk("drained_count", 32'(count), 32'd0);
        chk("drained_data",  bus.out_data, 32'd0);
        bus.out_ready = 1'b0;

        // Wrap-around: hold two entries while streaming through
        bus.in_valid = 1'b1;
        bus.in_data = 32'hA0; step();
        bus.in_data = 32'hA1; step();
        q.push_back(32'hA0);
        q.push_back(32'hA1);
        chk("wrap_pre_count", 32'(count), 32'd2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = 32'hB0 + 32'(i);
            head = q.pop_front();
            chk("wrap_data", bus.out_data, head);
            q.push_back(bus.in_data);
            step();
            chk("wrap_count", 32'(count), 32'd2);
        end
        chk("wrap_tail_head", bus.out_data, 32'hB8);

        // Bring count to 3, then flush with a word on the input
        bus.out_ready = 1'b0;
        bus.in_data = 32'hC0;
        step();
        chk("preflush_count", 32'(count), 32'd3);
        chk("preflush_afull", 32'(almost_full), 32'd1);
        flush = 1'b1;
        bus.in_data = 32'hEE;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_count",    32'(count), 32'd0);
        chk("flush_valid",    32'(bus.out_valid), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h77;
        step();
        bus.in_valid = 1'b0;
        chk("postflush_count", 32'(count), 32'd1);
        chk("postflush_data",  bus.out_data, 32'h77);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("postflush_empty", 32'(count), 32'd0);

        // Empty FIFO, producer and consumer both active
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hDEADBEEF;
        bus.out_ready = 1'b1;
        #1;
`ifdef OPERAND_FIFO_BYPASS_EN
        chk("byp_valid", 32'(bus.out_valid), 32'd1);
        chk("byp_data",  bus.out_data, 32'hDEADBEEF);
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("byp_count", 32'(count), 32'd0);
`else
        chk("nobyp_valid", 32'(bus.out_valid), 32'd0);
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("nobyp_count", 32'(count), 32'd1);
        chk("nobyp_data",  bus.out_data, 32'hDEADBEEF);
`endif

        // Asynchronous reset mid-transfer, then first edge after release
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h66;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_data",  bus.out_data, 32'd0);
        step();
        rst_n = 1'b1;
        bus.in_data = 32'h99;
        step();
        bus.in_valid = 1'b0;
        chk("rel_count", 32'(count), 32'd1);
        chk("rel_data",  bus.out_data, 32'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fifo.md
Name: operand_fifo

Overview:
- Elastic 32-bit operand buffer that sits directly downstream of the PE output register stage.
- Absorbs registered results and presents them to the next PE / interconnect port with a valid/ready handshake.
- Decouples producer timing from consumer stalls, so a stalled consumer never loses a registered result.
- Register-based storage, single clock domain.

Parameters:
- DATA_W, 32, operand width in bits.
- DEPTH, 4, number of entries; power of two, minimum 2.
- AFULL_TH, 3, count at or above which almost_full asserts; range 1..DEPTH.
- AW (localparam), log2(DEPTH), pointer width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all contents.
- in_valid  input  1  producer has data on in_data.
- in_data  input  DATA_W  producer data.
- in_ready  output  1  FIFO can accept this cycle.
- out_valid  output  1  out_data holds the head entry.
- out_data  output  DATA_W  head entry.
- out_ready  input  1  consumer accepts this cycle.
- count  output  AW+1  number of stored entries, 0..DEPTH.
- almost_full  output  1  count >= AFULL_TH.

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr and count go to 0; storage clears to 0.
  - in_ready=1, out_valid=0, out_data=0, almost_full=0.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It is independent of out_ready, so there is no push into a full FIFO even when a pop happens in the same cycle.
- out_valid = (count != 0).
- out_data = storage[rd_ptr] when out_valid, else 0.
- Latency: a word pushed at edge N is visible on out_valid/out_data after edge N (next cycle). Minimum push-to-pop latency is 1 cycle.
- Push writes storage[wr_ptr]; wr_ptr increments modulo DEPTH (natural AW-bit wrap).
- Pop increments rd_ptr modulo DEPTH.
- count update: push only +1; pop only -1; push and pop together: unchanged; neither: unchanged.
- Ordering is strictly FIFO; no reordering and no drops.
- flush has priority over push and pop in the same cycle. Pointers and count go to 0; storage is not cleared; the push in that cycle is discarded.
- almost_full and count are combinational from registered state, so they carry no extra latency.
- Holding rules:
  - Producer must hold in_data stable while in_valid & !in_ready.
  - The FIFO holds out_data stable while out_valid & !out_ready.
- Reset asserted mid-transfer aborts everything immediately. After release the FIFO is empty and the first push is accepted on the first rising edge with rst_n high.

Optional Feature:
- Macro: OPERAND_FIFO_BYPASS_EN.
- Defined: when count==0 and in_valid, out_valid=1 and out_data=in_data combinationally.
  - If out_ready is also high, the word is consumed the same cycle (0-cycle latency) and is not stored; count stays 0.
  - If out_ready is low, the word is stored normally.
- Undefined: no combinational in-to-out path; minimum latency 1 cycle as above.

Decomposition:
- Shared package daric_pkg holds:
  - constant DATA_W=32;
  - typedef data_t (logic [DATA_W-1:0]);
  - function clog2-based pointer width helper.
- One natural sub-module: fifo_ptr_ctr. It is an AW-bit wrapping pointer with increment enable and synchronous clear, instantiated twice (write, read).
- Storage, count and flag logic stay in operand_fifo.

Test Plan:
- Reset then idle, DEPTH=4 -> in_ready=1, out_valid=0, out_data=0, count=0, almost_full=0.
- Push 0x11,0x22,0x33,0x44 back-to-back with out_ready=0:
  - count reaches 4; in_ready=0 after the 4th edge; almost_full=1 from count=3.
  - A 5th word 0x55 held on in_valid is not accepted.
- Full FIFO, out_ready=1 for 4 cycles -> out_data sequence 0x11,0x22,0x33,0x44; then out_valid=0 and count=0.
- Wrap-around: 10 cycles of simultaneous push/pop at count=2 -> count stays 2 and output order matches input order across pointer wrap.
- flush with in_valid=1 and count=3 -> next cycle count=0, out_valid=0; the flushed-cycle word is absent.
- With OPERAND_FIFO_BYPASS_EN defined, empty FIFO, in_valid=1, in_data=0xDEADBEEF, out_ready=1 -> same cycle out_valid=1, out_data=0xDEADBEEF, count stays 0. Without the macro, out_valid=0 that cycle and count=1 next cycle.
